// File: rtl/snake_pkg.sv
// Shared encodings for the snake step sequencer: game states, directions, step phases.
// Optional feature macro used by the sequencer: PAUSE_EN.
package snake_pkg;

    localparam logic [2:0] GS_INIT       = 3'd0;
    localparam logic [2:0] GS_BASIC      = 3'd1;
    localparam logic [2:0] GS_INVINCIBLE = 3'd2;
    localparam logic [2:0] GS_DEAD       = 3'd3;
    localparam logic [2:0] GS_WIN        = 3'd4;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    typedef enum logic [2:0] {
        PH_IDLE,
        PH_WAIT,
        PH_MOVE,
        PH_CHECK,
        PH_SPAWN
    } phase_t;

    // Up/down and left/right differ only in bit 1.
    function automatic logic [1:0] opposite_dir(input logic [1:0] d);
        return d ^ 2'd2;
    endfunction

    function automatic logic is_play(input logic [2:0] gs);
        return (gs == GS_BASIC) || (gs == GS_INVINCIBLE);
    endfunction

endpackage

// File: rtl/snake_step_sequencer_if.sv
// Step handshakes between the sequencer (master) and the snake datapath (slave).
interface snake_step_sequencer_if;

    logic       move_req;
    logic       move_ack;
    logic [1:0] dir_out;
    logic       chk_req;
    logic       chk_ack;
    logic       ate_fruit;
    logic       ate_i_fruit;
    logic       spawn_req;
    logic       spawn_ack;

    modport master (
        output move_req, dir_out, chk_req, spawn_req,
        input  move_ack, chk_ack, ate_fruit, ate_i_fruit, spawn_ack
    );

    modport slave (
        input  move_req, dir_out, chk_req, spawn_req,
        output move_ack, chk_ack, ate_fruit, ate_i_fruit, spawn_ack
    );

endinterface

// File: rtl/step_tick_gen.sv
// Movement tick generator: counts enabled clk cycles and pulses o_tick every TICK_DIV of them.
module step_tick_gen #(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    output logic o_tick
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == LAST);
    assign o_tick = i_en && w_wrap;

    // Counter holds its value while disabled so a paused tick period resumes where it left off.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/snake_step_sequencer.sv
// One game step per movement tick: move -> check -> optional spawn, plus length and invincibility tracking.
// Define PAUSE_EN to add the i_pause input that freezes ticks and step starts.
module snake_step_sequencer
    import snake_pkg::*;
#(
    parameter int TICK_DIV  = 25_000_000,
    parameter int INV_STEPS = 7,
    parameter int INIT_LEN  = 3,
    parameter int WIN_LEN   = 16,
    parameter int LEN_W     = 5
) (
    input  logic                 clk,
    input  logic                 reset,
`ifdef PAUSE_EN
    input  logic                 i_pause,
`endif
    input  logic [2:0]           i_game_state,
    input  logic [1:0]           i_dir_in,
    input  logic                 i_dir_valid,
    snake_step_sequencer_if.master bus,
    output logic                 o_touch_i_fruit,
    output logic [2:0]           o_count_down,
    output logic                 o_long_enough,
    output logic [LEN_W-1:0]     o_snake_len,
    output logic                 o_step_overrun
);

    localparam logic [LEN_W-1:0] LEN_MAX  = '1;
    localparam logic [LEN_W-1:0] LEN_INIT = LEN_W'(INIT_LEN);
    localparam logic [LEN_W-1:0] LEN_WIN  = LEN_W'(WIN_LEN);
    localparam logic [2:0]       CD_INIT  = 3'(INV_STEPS);

    phase_t           r_phase;
    phase_t           w_phase_nxt;
    logic             r_pending;
    logic             r_overrun;
    logic             r_touch;
    logic             r_long;
    logic [1:0]       r_dir_latch;
    logic [1:0]       r_dir_out;
    logic [2:0]       r_count_down;
    logic [LEN_W-1:0] r_snake_len;
    logic [LEN_W-1:0] w_len_nxt;
    logic             w_play;
    logic             w_hold;
    logic             w_tick;
    logic             w_consume;
    logic             w_chk_done;
    logic             w_ate_any;

    assign w_play = is_play(i_game_state);
`ifdef PAUSE_EN
    assign w_hold = i_pause;
`else
    assign w_hold = 1'b0;
`endif

    step_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .i_en   (w_play && !w_hold),
        .o_tick (w_tick)
    );

    assign w_ate_any  = bus.ate_fruit | bus.ate_i_fruit;
    assign w_chk_done = (r_phase == PH_CHECK) && bus.chk_ack;

    // A handshake in flight always finishes; leaving play only redirects the following phase to IDLE.
    always_comb begin
        w_phase_nxt   = r_phase;
        w_consume     = 1'b0;
        bus.move_req  = 1'b0;
        bus.chk_req   = 1'b0;
        bus.spawn_req = 1'b0;
        case (r_phase)
            PH_IDLE: begin
                if (w_play) w_phase_nxt = PH_WAIT;
            end
            PH_WAIT: begin
                if (!w_play) begin
                    w_phase_nxt = PH_IDLE;
                end else if (r_pending && !w_hold) begin
                    w_phase_nxt = PH_MOVE;
                    w_consume   = 1'b1;
                end
            end
            PH_MOVE: begin
                bus.move_req = 1'b1;
                if (bus.move_ack) w_phase_nxt = w_play ? PH_CHECK : PH_IDLE;
            end
            PH_CHECK: begin
                bus.chk_req = 1'b1;
                if (bus.chk_ack) begin
                    if (!w_play)        w_phase_nxt = PH_IDLE;
                    else if (w_ate_any) w_phase_nxt = PH_SPAWN;
                    else                w_phase_nxt = PH_WAIT;
                end
            end
            PH_SPAWN: begin
                bus.spawn_req = 1'b1;
                if (bus.spawn_ack) w_phase_nxt = w_play ? PH_WAIT : PH_IDLE;
            end
            default: w_phase_nxt = PH_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase     <= PH_IDLE;
            r_pending   <= 1'b0;
            r_overrun   <= 1'b0;
            r_dir_latch <= DIR_RIGHT;
            r_dir_out   <= DIR_RIGHT;
        end else begin
            r_phase <= w_phase_nxt;
            if (w_tick) begin
                r_pending <= 1'b1;
                if (r_pending && !w_consume) r_overrun <= 1'b1;
            end else if (w_consume) begin
                r_pending <= 1'b0;
            end
            if (w_consume) r_dir_out <= r_dir_latch;
            if (i_dir_valid && (i_dir_in != opposite_dir(r_dir_out))) r_dir_latch <= i_dir_in;
        end
    end

    assign w_len_nxt = (w_chk_done && bus.ate_fruit && (r_snake_len != LEN_MAX))
                     ? r_snake_len + 1'b1 : r_snake_len;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_snake_len  <= LEN_INIT;
            r_long       <= 1'b0;
            r_touch      <= 1'b0;
            r_count_down <= 3'd0;
        end else begin
            r_snake_len <= w_len_nxt;
            r_long      <= (w_len_nxt >= LEN_WIN);
            r_touch     <= w_chk_done && bus.ate_i_fruit;
            if (!w_play) begin
                r_count_down <= 3'd0;
            end else if (w_chk_done && bus.ate_i_fruit) begin
                r_count_down <= CD_INIT;
            end else if (w_chk_done && (i_game_state == GS_INVINCIBLE) && (r_count_down != 3'd0)) begin
                r_count_down <= r_count_down - 1'b1;
            end
        end
    end

    assign bus.dir_out     = r_dir_out;
    assign o_touch_i_fruit = r_touch;
    assign o_count_down    = r_count_down;
    assign o_long_enough   = r_long;
    assign o_snake_len     = r_snake_len;
    assign o_step_overrun  = r_overrun;

endmodule

// File: tb/tb_snake_step_sequencer.sv
// Self-checking bench: directed scenarios plus randomized play against a step-level reference model.
module tb_snake_step_sequencer;
    import snake_pkg::*;

    localparam int TICK_DIV  = 4;
    localparam int INV_STEPS = 3;
    localparam int INIT_LEN  = 3;
    localparam int WIN_LEN   = 5;
    localparam int LEN_W     = 5;
    localparam int LEN_SAT   = (1 << LEN_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [2:0]       game_state;
    logic [1:0]       dir_in;
    logic             dir_valid;
    logic             touch;
    logic [2:0]       count_down;
    logic             long_enough;
    logic [LEN_W-1:0] snake_len;
    logic             overrun;
`ifdef PAUSE_EN
    logic             pause = 1'b0;
`endif

    snake_step_sequencer_if bus();

    snake_step_sequencer #(
        .TICK_DIV (TICK_DIV), .INV_STEPS (INV_STEPS), .INIT_LEN (INIT_LEN),
        .WIN_LEN (WIN_LEN), .LEN_W (LEN_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
`ifdef PAUSE_EN
        .i_pause         (pause),
`endif
        .i_game_state    (game_state),
        .i_dir_in        (dir_in),
        .i_dir_valid     (dir_valid),
        .bus             (bus),
        .o_touch_i_fruit (touch),
        .o_count_down    (count_down),
        .o_long_enough   (long_enough),
        .o_snake_len     (snake_len),
        .o_step_overrun  (overrun)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Reference model state
    int         m_len, m_cd, m_cnt, exp_next;
    bit         m_touch, m_pend, m_ovr;
    logic [1:0] m_dir, m_latch;
    bit         ev_chk, ev_move_rise;
    int         cyc_n = 0;

    // Responder knobs
    int wcnt = 0, maxd = 0, fruit_pct = 0, ifruit_pct = 0;
    bit stray_en = 0, hold_move = 0;

    // Previous-cycle snapshot
    bit         d_reset, d_dir_valid, d_mack, d_cack, d_sack, d_af, d_ai;
    logic [2:0] d_gs;
    logic [1:0] d_dir_in;
    logic       q_mreq, q_creq, q_sreq;

    task automatic respond();
        bus.move_ack = 0; bus.chk_ack = 0; bus.spawn_ack = 0;
        bus.ate_fruit = 0; bus.ate_i_fruit = 0;
        if (hold_move && bus.move_req) begin
            wcnt = 10;
            hold_move = 0;
        end
        if (bus.move_req || bus.chk_req || bus.spawn_req) begin
            if (wcnt == 0) begin
                bus.move_ack  = bus.move_req;
                bus.chk_ack   = bus.chk_req;
                bus.spawn_ack = bus.spawn_req;
                if (bus.chk_req) begin
                    bus.ate_fruit   = (int'($urandom_range(0, 99)) < fruit_pct);
                    bus.ate_i_fruit = (int'($urandom_range(0, 99)) < ifruit_pct);
                end
                wcnt = int'($urandom_range(0, maxd));
            end else begin
                wcnt--;
            end
        end else if (stray_en && $urandom_range(0, 7) == 0) begin
            bus.move_ack    = 1'($urandom_range(0, 1));
            bus.chk_ack     = 1'($urandom_range(0, 1));
            bus.spawn_ack   = 1'($urandom_range(0, 1));
            bus.ate_fruit   = 1'($urandom_range(0, 1));
            bus.ate_i_fruit = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic model_and_check();
        bit play, tick, consumed, chk_done;
        logic [1:0] old_dir;
        ev_chk = 0;
        ev_move_rise = 0;
        if (d_reset) begin
            m_len = INIT_LEN; m_cd = 0; m_touch = 0; m_pend = 0; m_ovr = 0; m_cnt = 0;
            m_dir = DIR_RIGHT; m_latch = DIR_RIGHT; exp_next = 0;
        end else begin
            play = is_play(d_gs);
            tick = play && (m_cnt == TICK_DIV - 1);
            if (play) m_cnt = (m_cnt + 1) % TICK_DIV;
            consumed = !q_mreq && bus.move_req;
            old_dir = m_dir;
            if (consumed) begin
                check_eq("step_from_pending", 32'(m_pend), 1);
                check_eq("step_in_play", 32'(play), 1);
                check_eq("move_order", exp_next, 0);
                m_dir = m_latch;
                ev_move_rise = 1;
            end
            if (tick) begin
                if (m_pend && !consumed) m_ovr = 1;
                m_pend = 1;
            end else if (consumed) begin
                m_pend = 0;
            end
            if (d_dir_valid && d_dir_in != (old_dir ^ 2'd2)) m_latch = d_dir_in;

            chk_done = d_cack && q_creq;
            m_touch = chk_done && d_ai;
            if (chk_done && d_af && m_len < LEN_SAT) m_len++;
            if (!play) m_cd = 0;
            else if (chk_done && d_ai) m_cd = INV_STEPS;
            else if (chk_done && d_gs == GS_INVINCIBLE && m_cd > 0) m_cd--;

            if (q_mreq && d_mack) exp_next = play ? 1 : 0;
            if (chk_done) exp_next = (play && (d_af || d_ai)) ? 2 : 0;
            if (q_sreq && d_sack) exp_next = 0;

            if (q_mreq) check_eq(d_mack ? "move_req_drop" : "move_req_hold", 32'(bus.move_req), 32'(!d_mack));
            if (q_creq) check_eq(d_cack ? "chk_req_drop" : "chk_req_hold", 32'(bus.chk_req), 32'(!d_cack));
            if (q_sreq) check_eq(d_sack ? "spawn_req_drop" : "spawn_req_hold", 32'(bus.spawn_req), 32'(!d_sack));
            if (!q_creq && bus.chk_req) check_eq("chk_order", exp_next, 1);
            if (!q_sreq && bus.spawn_req) check_eq("spawn_order", exp_next, 2);
            ev_chk = chk_done;
        end
        check_eq("one_req", 32'(bus.move_req) + 32'(bus.chk_req) + 32'(bus.spawn_req) <= 1, 1);
        check_eq("snake_len", snake_len, m_len);
        check_eq("count_down", count_down, m_cd);
        check_eq("touch_i_fruit", touch, m_touch);
        check_eq("long_enough", long_enough, 32'(m_len >= WIN_LEN));
        check_eq("step_overrun", overrun, m_ovr);
        check_eq("dir_out", bus.dir_out, m_dir);
    endtask

    task automatic tick_cycle();
        respond();
        d_reset = reset; d_gs = game_state; d_dir_in = dir_in; d_dir_valid = dir_valid;
        d_mack = bus.move_ack; d_cack = bus.chk_ack; d_sack = bus.spawn_ack;
        d_af = bus.ate_fruit; d_ai = bus.ate_i_fruit;
        q_mreq = bus.move_req; q_creq = bus.chk_req; q_sreq = bus.spawn_req;
        @(posedge clk);
        #1;
        cyc_n++;
        model_and_check();
    endtask

    task automatic do_reset();
        reset = 1; game_state = GS_INIT; dir_valid = 0;
        tick_cycle();
        tick_cycle();
        reset = 0;
    endtask

    task automatic wait_move_rise(input int budget);
        int n = 0;
        do begin
            tick_cycle();
            n++;
        end while (!ev_move_rise && n < budget);
        check_eq("move_seen", 32'(ev_move_rise), 1);
    endtask

    task automatic wait_chk(input int budget);
        int n = 0;
        do begin
            tick_cycle();
            n++;
        end while (!ev_chk && n < budget);
        check_eq("chk_seen", 32'(ev_chk), 1);
    endtask

    initial begin
        int last, nreq;
        bus.move_ack = 0; bus.chk_ack = 0; bus.spawn_ack = 0;
        bus.ate_fruit = 0; bus.ate_i_fruit = 0;
        dir_in = DIR_UP; dir_valid = 0;

        // Reset state and steady stepping with zero-latency acks
        do_reset();
        check_eq("rst_move_req", bus.move_req, 0);
        check_eq("rst_snake_len", snake_len, INIT_LEN);
        check_eq("rst_dir_out", bus.dir_out, DIR_RIGHT);
        game_state = GS_BASIC;
        wait_move_rise(40);
        last = cyc_n;
        for (int i = 0; i < 5; i++) begin
            wait_move_rise(40);
            check_eq("move_period", cyc_n - last, TICK_DIV);
            last = cyc_n;
        end

        // Reversal rejected, then a legal turn applied on the next move
        dir_in = DIR_LEFT; dir_valid = 1;
        tick_cycle();
        dir_valid = 0;
        wait_move_rise(40);
        check_eq("reverse_rejected", bus.dir_out, DIR_RIGHT);
        dir_in = DIR_UP; dir_valid = 1;
        tick_cycle();
        dir_valid = 0;
        wait_move_rise(40);
        check_eq("turn_up", bus.dir_out, DIR_UP);

        // Growth to WIN_LEN
        do_reset();
        game_state = GS_BASIC;
        fruit_pct = 100;
        wait_chk(60);
        check_eq("len_after_1", snake_len, 4);
        check_eq("long_after_1", long_enough, 0);
        wait_chk(60);
        check_eq("len_after_2", snake_len, 5);
        check_eq("long_after_2", long_enough, 1);
        fruit_pct = 0;

        // Invincibility fruit and countdown
        game_state = GS_INVINCIBLE;
        ifruit_pct = 100;
        wait_chk(60);
        check_eq("touch_pulse", touch, 1);
        check_eq("cd_load", count_down, INV_STEPS);
        ifruit_pct = 0;
        tick_cycle();
        check_eq("touch_one_cycle", touch, 0);
        for (int i = INV_STEPS - 1; i >= 0; i--) begin
            wait_chk(60);
            check_eq("cd_step", count_down, i);
        end
        wait_chk(60);
        check_eq("cd_floor", count_down, 0);

        // Stalled move_ack causes a dropped tick
        do_reset();
        check_eq("rst_overrun", overrun, 0);
        game_state = GS_BASIC;
        hold_move = 1;
        wait_move_rise(40);
        for (int i = 0; i < 14; i++) tick_cycle();
        check_eq("overrun_set", overrun, 1);

        // Reset in the middle of a check handshake, then Dead holds the sequencer idle
        do_reset();
        game_state = GS_BASIC;
        maxd = 3;
        fruit_pct = 100;
        begin
            int n = 0;
            do begin
                tick_cycle();
                n++;
            end while (!bus.chk_req && n < 60);
            check_eq("chk_req_seen", bus.chk_req, 1);
        end
        reset = 1;
        tick_cycle();
        reset = 0;
        game_state = GS_DEAD;
        check_eq("mid_rst_reqs", 32'(bus.move_req | bus.chk_req | bus.spawn_req), 0);
        check_eq("mid_rst_len", snake_len, INIT_LEN);
        check_eq("mid_rst_cd", count_down, 0);
        nreq = 0;
        for (int i = 0; i < 20; i++) begin
            tick_cycle();
            nreq += int'(bus.move_req | bus.chk_req | bus.spawn_req);
        end
        check_eq("dead_no_req", nreq, 0);

        // Randomized play
        do_reset();
        game_state = GS_BASIC;
        stray_en = 1; maxd = 3; fruit_pct = 50; ifruit_pct = 20;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                if ($urandom_range(0, 9) < 7) game_state = 3'($urandom_range(1, 2));
                else begin
                    case ($urandom_range(0, 2))
                        0:       game_state = GS_INIT;
                        1:       game_state = GS_DEAD;
                        default: game_state = GS_WIN;
                    endcase
                end
            end
            dir_valid = ($urandom_range(0, 3) == 0);
            dir_in = 2'($urandom_range(0, 3));
            reset = ($urandom_range(0, 499) == 0);
            tick_cycle();
        end
        reset = 0;
        dir_valid = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
